// File: rtl/alu_pkg.sv
// Shared ALU function codes and the per-requester operation bundle.
// bit3 of funct selects SUB over ADD and SRA over SRL.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  funct;
  } alu_req_t;

  function automatic logic [4:0] shamt(input logic [31:0] v);
    return v[4:0];
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU shared through alu_arbiter.
// Undefined funct codes return zero.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic [3:0]  funct_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = '0;
    case (funct_i)
      ALU_ADD:  result_o = src1_i + src2_i;
      ALU_SUB:  result_o = src1_i - src2_i;
      ALU_SLL:  result_o = src1_i << shamt(src2_i);
      ALU_SLT:  result_o = {31'd0, $signed(src1_i) < $signed(src2_i)};
      ALU_SLTU: result_o = {31'd0, src1_i < src2_i};
      ALU_XOR:  result_o = src1_i ^ src2_i;
      ALU_SRL:  result_o = src1_i >> shamt(src2_i);
      ALU_SRA:  result_o = $unsigned($signed(src1_i) >>> shamt(src2_i));
      ALU_OR:   result_o = src1_i | src2_i;
      ALU_AND:  result_o = src1_i & src2_i;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester after ptr_i, wrapping.
// The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_i[i] && (i == (int'(ptr_i) + k) % NREQ)) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between NREQ requesters with round-robin grant
// and a single registered, owner-tagged result slot.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_src1,
  input  logic [NREQ*32-1:0] req_src2,
  input  logic [NREQ*4-1:0] req_funct,
  output logic [31:0]       alu_src1,
  output logic [31:0]       alu_src2,
  output logic [3:0]        alu_funct,
  input  logic [31:0]       alu_result,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [31:0]       rsp_result
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_EMPTY, S_FULL} slot_state_e;

  slot_state_e      state_q;
  logic [NREQ-1:0]  rsp_valid_q;
  logic [31:0]      rsp_result_q;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  grant_raw, grant;
  logic             drain, can_accept, accept;
  alu_req_t         sel;

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant_raw)
  );

  // No grant while in reset, so requesters never see a handshake that is then discarded.
  assign grant      = reset ? '0 : grant_raw;
  assign drain      = |(rsp_valid_q & rsp_ready);
  assign can_accept = (state_q == S_EMPTY) | drain;
  assign req_ready  = grant & {NREQ{can_accept}};
  assign accept     = |req_ready;

  always_comb begin
    sel   = '0;
    ptr_d = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel.src1  = req_src1[i*32 +: 32];
        sel.src2  = req_src2[i*32 +: 32];
        sel.funct = req_funct[i*4 +: 4];
        ptr_d     = PTR_W'(i);
      end
    end
  end

  assign alu_src1  = sel.src1;
  assign alu_src2  = sel.src2;
  assign alu_funct = sel.funct;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_EMPTY;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      ptr_q        <= PTR_W'(NREQ - 1);
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_q      <= S_FULL;
            rsp_valid_q  <= req_ready;
            rsp_result_q <= alu_result;
            ptr_q        <= ptr_d;
          end
        end
        S_FULL: begin
          if (accept) begin
            rsp_valid_q  <= req_ready;
            rsp_result_q <= alu_result;
            ptr_q        <= ptr_d;
          end else if (drain) begin
            state_q     <= S_EMPTY;
            rsp_valid_q <= '0;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter driving the real alu: directed scenarios then random traffic,
// each cycle compared against a behavioural slot/round-robin model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_src1, req_src2;
  logic [NREQ*4-1:0]   req_funct;
  logic [31:0]         alu_src1, alu_src2, alu_result, rsp_result;
  logic [3:0]          alu_funct;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .req_funct  (req_funct),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_funct  (alu_funct),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result)
  );

  alu u_alu (
    .src1_i   (alu_src1),
    .src2_i   (alu_src2),
    .funct_i  (alu_funct),
    .result_o (alu_result)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // requester-side stimulus
  logic        v_a [NREQ];
  logic [3:0]  f_a [NREQ];
  logic [31:0] a_a [NREQ];
  logic [31:0] b_a [NREQ];

  // reference model state
  bit          m_full;
  int          m_owner;
  int          m_ptr;
  logic [31:0] m_result;
  logic [NREQ-1:0] last_ready;

  logic [3:0] fun_tab [10] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                              ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};

  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (f)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << sh;
      ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return 32'(sa >>> sh);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] f,
                         input logic [31:0] a, input logic [31:0] b);
    v_a[i] = v;
    f_a[i] = f;
    a_a[i] = a;
    b_a[i] = b;
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = v_a[i];
      req_funct[i*4 +: 4]   = f_a[i];
      req_src1[i*32 +: 32]  = a_a[i];
      req_src2[i*32 +: 32]  = b_a[i];
    end
  endtask

  // Entered 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic cycle(input string tag);
    int              g;
    bit              can;
    logic [NREQ-1:0] er, ev;
    apply();
    #4;
    g = -1;
    if (!reset) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (g < 0 && v_a[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    can = !m_full || rsp_ready[m_owner];
    er  = (g >= 0 && can) ? NREQ'(1 << g) : '0;
    ev  = m_full ? NREQ'(1 << m_owner) : '0;
    last_ready = req_ready;
    chk({tag, ":req_ready"},  32'(req_ready), 32'(er));
    chk({tag, ":rsp_valid"},  32'(rsp_valid), 32'(ev));
    chk({tag, ":rsp_result"}, rsp_result, m_result);
    chk({tag, ":alu_funct"},  32'(alu_funct), (g >= 0) ? 32'(f_a[g]) : 32'd0);
    chk({tag, ":alu_src1"},   alu_src1, (g >= 0) ? a_a[g] : 32'd0);
    chk({tag, ":alu_src2"},   alu_src2, (g >= 0) ? b_a[g] : 32'd0);
    @(posedge clk);
    if (reset) begin
      m_full   = 1'b0;
      m_owner  = 0;
      m_result = '0;
      m_ptr    = NREQ - 1;
    end else if (er != '0) begin
      m_full   = 1'b1;
      m_owner  = g;
      m_ptr    = g;
      m_result = ref_alu(f_a[g], a_a[g], b_a[g]);
    end else if (m_full && rsp_ready[m_owner]) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, ALU_ADD, 32'd0, 32'd0);
  endtask

  initial begin
    logic [NREQ-1:0] seq3 [4];
    seq3 = '{2'b01, 2'b10, 2'b01, 2'b10};
    reset     = 1'b1;
    rsp_ready = '0;
    idle_all();
    apply();
    @(posedge clk);
    #1;
    m_full = 1'b0; m_owner = 0; m_ptr = NREQ - 1; m_result = '0;

    // 1: reset held with random request traffic
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'($urandom_range(0, 1)), ALU_ADD, $urandom, $urandom);
      cycle("t1_reset");
    end
    chk("t1_rsp_valid_after", 32'(rsp_valid), 32'd0);
    chk("t1_rsp_result_after", rsp_result, 32'd0);

    // 2: single ADD, one-cycle latency
    reset = 1'b0;
    rsp_ready = '1;
    idle_all();
    set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
    cycle("t2_issue");
    chk("t2_ready_cycleN", 32'(last_ready), 32'b01);
    chk("t2_rsp_valid", 32'(rsp_valid), 32'b01);
    chk("t2_rsp_result", rsp_result, 32'd12);
    idle_all();
    cycle("t2_drain");

    // 3: both requesters back-to-back after a fresh reset
    reset = 1'b1;
    cycle("t3_reset");
    reset = 1'b0;
    set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
    set_req(1, 1'b1, ALU_SUB, 32'd10, 32'd3);
    for (int c = 0; c < 4; c++) begin
      cycle("t3_alt");
      chk("t3_grant_seq", 32'(last_ready), 32'(seq3[c]));
      chk("t3_result", rsp_result, seq3[c][1] ? 32'd7 : 32'd12);
    end

    // 4: owner stalls, competing requester must wait
    idle_all();
    set_req(0, 1'b1, ALU_XOR, 32'hFF, 32'h0F);
    cycle("t4_xor");
    chk("t4_xor_result", rsp_result, 32'hF0);
    idle_all();
    set_req(1, 1'b1, ALU_SUB, 32'd10, 32'd3);
    rsp_ready = 2'b10;
    for (int c = 0; c < 3; c++) begin
      cycle("t4_stall");
      chk("t4_stall_ready", 32'(last_ready), 32'd0);
      chk("t4_stall_hold", rsp_result, 32'hF0);
    end
    rsp_ready = 2'b11;
    cycle("t4_release");
    chk("t4_release_ready", 32'(last_ready), 32'b10);
    chk("t4_release_result", rsp_result, 32'd7);

    // 5: arithmetic vs logical right shift
    set_req(1, 1'b1, ALU_SRA, 32'h8000_0000, 32'd4);
    cycle("t5_sra");
    chk("t5_sra_result", rsp_result, 32'hF800_0000);
    chk("t5_sra_valid", 32'(rsp_valid), 32'b10);
    set_req(1, 1'b1, ALU_SRL, 32'h8000_0000, 32'd4);
    cycle("t5_srl");
    chk("t5_srl_result", rsp_result, 32'h0800_0000);
    chk("t5_srl_valid", 32'(rsp_valid), 32'b10);
    idle_all();
    cycle("t5_drain");

    // 6: reset while FULL and owner stalled
    set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
    cycle("t6_fill");
    idle_all();
    rsp_ready = '0;
    cycle("t6_hold");
    reset = 1'b1;
    cycle("t6_reset");
    chk("t6_rsp_valid_cleared", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    rsp_ready = '1;
    set_req(0, 1'b1, ALU_OR, 32'h0F00, 32'h00F0);
    set_req(1, 1'b1, ALU_AND, 32'hFFFF, 32'h0F0F);
    cycle("t6_first");
    chk("t6_req0_wins", 32'(last_ready), 32'b01);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        logic [31:0] b;
        b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
        set_req(i, ($urandom_range(0, 9) < 7), fun_tab[$urandom_range(0, 9)], $urandom, b);
      end
      for (int i = 0; i < NREQ; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 49) == 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
